ctrl_pipe: RTL
==============

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-002 Clock and reset: one clock, clk; reset is asynchronous and active-high, reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 id_valid  input  1  decode stage holds a real instruction this cycle.
REQ-006 id_is_jal, id_is_jalr, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_write_enable, id_pc_to_reg, id_is_ecall  input  1 each  decoded control bits from the control unit.
REQ-007 id_rd  input  5  destination register of the decode-stage instruction.
REQ-008 stall  input  1  load-use hazard: insert a bubble into EX this cycle.
REQ-009 flush  input  1  taken branch/jump resolved in EX: kill the decode-stage instruction.
REQ-010 ex_valid, ex_is_jal, ex_is_jalr, ex_branch, ex_alu_src, ex_mem_read  output  1 each  EX-stage controls.
REQ-011 ex_rd  output  5  EX-stage destination.
REQ-012 mem_valid, mem_mem_read, mem_mem_write  output  1 each  MEM-stage controls.
REQ-013 mem_rd  output  5; mem_reg_write  output  1  MEM-stage destination and forwarding qualifier.
REQ-014 wb_valid, wb_mem_to_reg, wb_pc_to_reg, wb_reg_write  output  1 each  WB-stage controls.
REQ-015 wb_rd  output  5  WB-stage destination.
REQ-016 is_halted  output  1  sticky; ecall has retired.
REQ-017 retired  output  CNT_W  count of instructions completing WB.

Function
REQ-018 The block SHALL hold three registered stages EX, MEM, WB, each with a valid bit; every stage register updates on each rising clk edge (no hold path).
REQ-019 EX SHALL load the id_* bundle with ex_valid=id_valid when stall=0, flush=0 and is_halted=0; otherwise EX SHALL load a bubble (valid=0, all control bits 0, rd=0).
REQ-020 stall and flush asserted together SHALL produce one bubble, identical to either alone.
REQ-021 MEM SHALL load EX contents and WB SHALL load MEM contents every cycle, unaffected by stall, flush or is_halted.
REQ-022 Latency: an instruction accepted in cycle N SHALL appear at EX in N+1, MEM in N+2, WB in N+3.
REQ-023 Every stage output control bit SHALL be the stored bit ANDed with that stage's valid bit.
REQ-024 mem_reg_write and wb_reg_write SHALL equal valid AND write_enable AND (rd != 0).
REQ-025 retired SHALL increment by 1 on each edge where wb_valid=1, wrapping from 2^CNT_W-1 to 0.
REQ-026 is_halted SHALL set on the edge where wb_valid=1 and the WB is_ecall bit is 1, and SHALL remain 1 until reset; the ecall instruction itself SHALL be counted in retired.
REQ-027 After is_halted=1, remaining in-flight instructions SHALL drain through WB and be counted; no new instruction SHALL enter.
REQ-028 Outputs SHALL be combinational functions of stage registers only (no input-to-output paths).

Reset
REQ-029 reset=1 SHALL immediately, without waiting for clk, clear all valid bits, all stored controls, all rd fields, retired to 0 and is_halted to 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight instructions; the first edge after deassertion SHALL behave as REQ-019 with clean state.

Verification
REQ-031 Reset pulse then id_valid=1, id_mem_read=1, id_mem_to_reg=1, id_write_enable=1, id_rd=5 for one cycle -> ex_mem_read=1 at N+1, mem_mem_read=1 and mem_reg_write=1 at N+2, wb_mem_to_reg=1, wb_rd=5 at N+3, retired=1 after.
REQ-032 Valid instruction with stall=1 -> ex_valid=0 next cycle, all ex_* 0; a prior instruction already in EX still reaches MEM; stall+flush together -> exactly one bubble.
REQ-033 Valid write instruction with id_rd=0 -> mem_reg_write=0 and wb_reg_write=0, but retired still increments.
REQ-034 Ecall followed by 3 valid instructions -> is_halted rises the edge ecall is in WB, the two instructions ahead of ecall counted, instructions issued after halt not accepted, is_halted stays 1 for 20 further cycles.
REQ-035 Preload retired to 2^CNT_W-1 via continuous valid stream (CNT_W=4: 15 retirements) -> next retirement gives retired=0.
REQ-036 Assert reset asynchronously between edges with all three stages valid -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Decode-side control bundle plus the EX/MEM/WB control outputs of ctrl_pipe.
// The slave modport is the pipeline; the master modport is whoever drives decode.
interface ctrl_pipe_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             id_is_jal;
    logic             id_is_jalr;
    logic             id_branch;
    logic             id_mem_read;
    logic             id_mem_to_reg;
    logic             id_mem_write;
    logic             id_alu_src;
    logic             id_write_enable;
    logic             id_pc_to_reg;
    logic             id_is_ecall;
    logic [4:0]       id_rd;
    logic             stall;
    logic             flush;

    logic             ex_valid;
    logic             ex_is_jal;
    logic             ex_is_jalr;
    logic             ex_branch;
    logic             ex_alu_src;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             mem_valid;
    logic             mem_mem_read;
    logic             mem_mem_write;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             wb_valid;
    logic             wb_mem_to_reg;
    logic             wb_pc_to_reg;
    logic             wb_reg_write;
    logic [4:0]       wb_rd;
    logic             is_halted;
    logic [CNT_W-1:0] retired;

    modport slave (
        input  id_valid, id_is_jal, id_is_jalr, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_write_enable, id_pc_to_reg, id_is_ecall,
               id_rd, stall, flush,
        output ex_valid, ex_is_jal, ex_is_jalr, ex_branch, ex_alu_src, ex_mem_read, ex_rd,
               mem_valid, mem_mem_read, mem_mem_write, mem_rd, mem_reg_write,
               wb_valid, wb_mem_to_reg, wb_pc_to_reg, wb_reg_write, wb_rd,
               is_halted, retired
    );

    modport master (
        output id_valid, id_is_jal, id_is_jalr, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_write_enable, id_pc_to_reg, id_is_ecall,
               id_rd, stall, flush,
        input  ex_valid, ex_is_jal, ex_is_jalr, ex_branch, ex_alu_src, ex_mem_read, ex_rd,
               mem_valid, mem_mem_read, mem_mem_write, mem_rd, mem_reg_write,
               wb_valid, wb_mem_to_reg, wb_pc_to_reg, wb_reg_write, wb_rd,
               is_halted, retired
    );
endinterface

// File: rtl/ctrl_pipe.sv
// EX/MEM/WB control-bit pipeline with bubble insertion on stall/flush/halt,
// a retired-instruction counter and a sticky halt flag raised by a retiring ecall.
module ctrl_pipe #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    ctrl_pipe_if.slave  pipe
);
    // Each stage only carries the bits still needed downstream of it.
    typedef struct packed {
        logic       valid;
        logic       is_jal;
        logic       is_jalr;
        logic       branch;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       write_enable;
        logic       pc_to_reg;
        logic       is_ecall;
        logic [4:0] rd;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       write_enable;
        logic       pc_to_reg;
        logic       is_ecall;
        logic [4:0] rd;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       mem_to_reg;
        logic       write_enable;
        logic       pc_to_reg;
        logic       is_ecall;
        logic [4:0] rd;
    } wb_t;

    ex_t              ex_q, ex_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             halted_q, halted_d;

    always_comb begin
        ex_d = '0;
        if (!pipe.stall && !pipe.flush && !halted_q) begin
            ex_d.valid        = pipe.id_valid;
            ex_d.is_jal       = pipe.id_is_jal;
            ex_d.is_jalr      = pipe.id_is_jalr;
            ex_d.branch       = pipe.id_branch;
            ex_d.alu_src      = pipe.id_alu_src;
            ex_d.mem_read     = pipe.id_mem_read;
            ex_d.mem_write    = pipe.id_mem_write;
            ex_d.mem_to_reg   = pipe.id_mem_to_reg;
            ex_d.write_enable = pipe.id_write_enable;
            ex_d.pc_to_reg    = pipe.id_pc_to_reg;
            ex_d.is_ecall     = pipe.id_is_ecall;
            ex_d.rd           = pipe.id_rd;
        end

        mem_d.valid        = ex_q.valid;
        mem_d.mem_read     = ex_q.mem_read;
        mem_d.mem_write    = ex_q.mem_write;
        mem_d.mem_to_reg   = ex_q.mem_to_reg;
        mem_d.write_enable = ex_q.write_enable;
        mem_d.pc_to_reg    = ex_q.pc_to_reg;
        mem_d.is_ecall     = ex_q.is_ecall;
        mem_d.rd           = ex_q.rd;

        wb_d.valid         = mem_q.valid;
        wb_d.mem_to_reg    = mem_q.mem_to_reg;
        wb_d.write_enable  = mem_q.write_enable;
        wb_d.pc_to_reg     = mem_q.pc_to_reg;
        wb_d.is_ecall      = mem_q.is_ecall;
        wb_d.rd            = mem_q.rd;

        retired_d = retired_q + CNT_W'(wb_q.valid);
        halted_d  = halted_q | (wb_q.valid & wb_q.is_ecall);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    // Qualify everything with the stage valid so a bubble never leaks stale bits.
    assign pipe.ex_valid      = ex_q.valid;
    assign pipe.ex_is_jal     = ex_q.valid & ex_q.is_jal;
    assign pipe.ex_is_jalr    = ex_q.valid & ex_q.is_jalr;
    assign pipe.ex_branch     = ex_q.valid & ex_q.branch;
    assign pipe.ex_alu_src    = ex_q.valid & ex_q.alu_src;
    assign pipe.ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign pipe.ex_rd         = {5{ex_q.valid}} & ex_q.rd;

    assign pipe.mem_valid     = mem_q.valid;
    assign pipe.mem_mem_read  = mem_q.valid & mem_q.mem_read;
    assign pipe.mem_mem_write = mem_q.valid & mem_q.mem_write;
    assign pipe.mem_rd        = {5{mem_q.valid}} & mem_q.rd;
    assign pipe.mem_reg_write = mem_q.valid & mem_q.write_enable & (|mem_q.rd);

    assign pipe.wb_valid      = wb_q.valid;
    assign pipe.wb_mem_to_reg = wb_q.valid & wb_q.mem_to_reg;
    assign pipe.wb_pc_to_reg  = wb_q.valid & wb_q.pc_to_reg;
    assign pipe.wb_rd         = {5{wb_q.valid}} & wb_q.rd;
    assign pipe.wb_reg_write  = wb_q.valid & wb_q.write_enable & (|wb_q.rd);

    assign pipe.is_halted     = halted_q;
    assign pipe.retired       = retired_q;
endmodule
